// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-FIFO read arbiter.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int NUM_REQ       = 2;
  localparam int POP_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    SETTLE  = 2'd2,
    DELIVER = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the one not granted last.
module rr_arb2
  import uart_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic               grant,
  output logic               grant_valid
);

  always_comb begin
    grant_valid = |req;
    grant       = (&req) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/rx_fifo_read_arb.sv
// Pops one character from the RX FIFO on behalf of one of two requesters and
// hands it over on that requester's rd_valid/rd_ready channel.
module rx_fifo_read_arb
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = DATA_BITS_DEF,
  parameter int POP_CYCLES    = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic                 fifo_overflow,
  input  logic [DATA_BITS-1:0] fifo_data,
  input  logic                 bist_mode,
  output logic                 pop_data,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   rd_ready,
  output logic [NUM_REQ-1:0]   rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 busy,
  output logic                 ovf_sticky,
  input  logic                 clr_status,
  output logic [POP_CNT_W-1:0] pop_cnt,
  output state_t               state_dbg
);

  localparam logic [1:0] POP_LAST    = 2'(POP_CYCLES - 1);
  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       grant_q;
  logic       last_grant;
  logic       arb_grant;
  logic       arb_valid;
  logic       deliver_done;

  rr_arb2 u_arb (
    .req         (req),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // Handshake: rd_valid[g] rises with rd_data already stable and stays up until
  // rd_ready[g] is sampled high; the transfer happens on that edge. rd_ready of
  // the other requester has no effect.
  assign deliver_done = (state == DELIVER) && rd_ready[grant_q];
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      pop_data   <= 1'b0;
      rd_valid   <= '0;
      rd_data    <= '0;
      busy       <= 1'b0;
      ovf_sticky <= 1'b0;
      pop_cnt    <= '0;
    end else begin
      ovf_sticky <= fifo_overflow | (ovf_sticky & ~clr_status);
      if (clr_status) begin
        pop_cnt <= '0;
      end else if (deliver_done) begin
        pop_cnt <= pop_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (!bist_mode && !fifo_empty && arb_valid) begin
            state    <= POP;
            grant_q  <= arb_grant;
            pop_data <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
          end
        end
        POP: begin
          if (cnt == POP_LAST) begin
            state    <= SETTLE;
            pop_data <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          // FIFO output has settled after the pop; capture it for delivery.
          if (cnt == SETTLE_LAST) begin
            state    <= DELIVER;
            rd_data  <= fifo_data;
            rd_valid <= grant_q ? 2'b10 : 2'b01;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DELIVER: begin
          if (deliver_done) begin
            state      <= IDLE;
            rd_valid   <= '0;
            last_grant <= grant_q;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_fifo_read_arb.sv
// Bench for rx_fifo_read_arb: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model and a data scoreboard.
module tb_rx_fifo_read_arb;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int P  = 1;
  localparam int S  = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_overflow;
  logic [DW-1:0] fifo_data;
  logic          bist_mode;
  logic          pop_data;
  logic [1:0]    req;
  logic [1:0]    rd_ready;
  logic [1:0]    rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          ovf_sticky;
  logic          clr_status;
  logic [15:0]   pop_cnt;
  state_t        state_dbg;

  always #5 clk = ~clk;

  rx_fifo_read_arb #(
    .DATA_BITS     (DW),
    .POP_CYCLES    (P),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_overflow (fifo_overflow),
    .fifo_data     (fifo_data),
    .bist_mode     (bist_mode),
    .pop_data      (pop_data),
    .req           (req),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .busy          (busy),
    .ovf_sticky    (ovf_sticky),
    .clr_status    (clr_status),
    .pop_cnt       (pop_cnt),
    .state_dbg     (state_dbg)
  );

  // FIFO contents: written by the driver, read pointer owned by the monitor
  logic [DW-1:0] fifo_mem [0:4095];
  int            wr_ptr = 0;
  int            rd_ptr = 0;

  // driver-owned
  int timeouts    = 0;
  int preload_seq = 0;
  bit tb_done     = 1'b0;

  // monitor-owned
  int            checks      = 0;
  int            failures    = 0;
  int            deliv_cnt   = 0;
  int            cyc         = 0;
  int            preload_seen = 0;
  logic [DW:0]   exp_q[$];
  int            m_t     = 0;
  logic          m_grant = 1'b0;
  logic          m_last  = 1'b1;
  logic [15:0]   m_cnt   = '0;
  logic          m_ovf   = 1'b0;
  logic [DW-1:0] m_hold  = '0;
  logic          pop_prev = 1'b0;
  logic          p_rst = 1'b1, p_bist = 1'b0, p_empty = 1'b1, p_clr = 1'b0, p_ovf = 1'b0;
  logic [1:0]    p_req = '0, p_ready = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rr_pick(input logic [1:0] r, input logic last);
    if (r == 2'b11) return ~last;
    return r[1];
  endfunction

  // Monitor: advance the model across the edge just passed, then compare.
  always @(negedge clk) begin
    logic        hs;
    logic [DW:0] e;
    state_t      exp_state;
    hs = 1'b0;
    cyc++;
    if (p_rst) begin
      m_t = 0; m_last = 1'b1; m_cnt = '0; m_ovf = 1'b0; m_hold = '0;
      exp_q.delete();
    end else begin
      m_ovf = p_ovf | (m_ovf & ~p_clr);
      hs = (m_t == P + S + 1) && p_ready[m_grant];
      if (p_clr) m_cnt = '0;
      else if (hs) m_cnt = m_cnt + 16'd1;
      if (m_t == 0) begin
        if (!p_bist && !p_empty && p_req != 2'b00) begin
          m_grant = rr_pick(p_req, m_last);
          m_t = 1;
          exp_q.push_back({m_grant, fifo_mem[rd_ptr]});
        end
      end else if (m_t <= P + S) begin
        m_t++;
      end else if (hs) begin
        m_t = 0;
        m_last = m_grant;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          m_hold = e[DW-1:0];
        end
        deliv_cnt++;
      end
    end
    if (preload_seq != preload_seen) begin
      preload_seen = preload_seq;
      m_cnt = 16'hFFFF;
    end

    if (m_t == 0)          exp_state = IDLE;
    else if (m_t <= P)     exp_state = POP;
    else if (m_t <= P + S) exp_state = SETTLE;
    else                   exp_state = DELIVER;

    check("pop_data", pop_data, (m_t >= 1 && m_t <= P));
    check("rd_valid", rd_valid, (m_t == P + S + 1) ? (m_grant ? 2'b10 : 2'b01) : 2'b00);
    check("busy", busy, m_t != 0);
    check("pop_cnt", pop_cnt, m_cnt);
    check("ovf_sticky", ovf_sticky, m_ovf);
    check("state_dbg", state_dbg, exp_state);
    if (m_t == P + S + 1 && exp_q.size() != 0) begin
      e = exp_q[0];
      check("rd_data_valid", rd_data, e[DW-1:0]);
    end else if (m_t != P + S + 1) begin
      check("rd_data_hold", rd_data, m_hold);
    end

    // FIFO behaviour: each pop_data pulse presents the next character
    if (pop_data && !pop_prev && rd_ptr != wr_ptr) begin
      fifo_data = fifo_mem[rd_ptr];
      rd_ptr++;
    end
    pop_prev   = pop_data;
    fifo_empty = (rd_ptr == wr_ptr);

    p_rst = rst; p_bist = bist_mode; p_empty = fifo_empty; p_clr = clr_status;
    p_ovf = fifo_overflow; p_req = req; p_ready = rd_ready;

    if (tb_done) begin
      check("timeouts", timeouts, 0);
      check("fifo_drained", wr_ptr - rd_ptr, 0);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (cyc > 60000) begin
      failures++;
      $display("FAIL watchdog: cycles=%0d limit=60000", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_deliv(input int target, input int budget);
    int n = 0;
    while (deliv_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    if (deliv_cnt < target) timeouts++;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (rd_valid == 2'b00 && n < budget) begin
      step(1);
      n++;
    end
    if (rd_valid == 2'b00) timeouts++;
  endtask

  task automatic wait_pop(input int budget);
    int n = 0;
    while (!pop_data && n < budget) begin
      step(1);
      n++;
    end
    if (!pop_data) timeouts++;
  endtask

  initial begin
    rst = 1'b1; req = '0; rd_ready = '0; bist_mode = 1'b0;
    fifo_overflow = 1'b0; clr_status = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    step(3);
    rst = 1'b0;
    step(2);

    // single requester, single character
    push(8'h41); req = 2'b01; rd_ready = 2'b01;
    wait_deliv(deliv_cnt + 1, 50);
    req = '0; rd_ready = '0;
    step(2);

    // tie held across three characters from a fresh reset
    do_reset();
    push(8'h10); push(8'h11); push(8'h12);
    step(1);
    req = 2'b11; rd_ready = 2'b11;
    wait_deliv(deliv_cnt + 3, 100);
    req = '0; rd_ready = '0;
    step(2);

    // stalled delivery, req dropped, wrong-side ready ignored
    push(8'h55); req = 2'b10; rd_ready = 2'b00;
    wait_valid(50);
    push(8'h56); req = 2'b00; rd_ready = 2'b01;
    step(10);
    rd_ready = 2'b10;
    wait_deliv(deliv_cnt + 1, 20);
    req = 2'b01; rd_ready = 2'b01;
    wait_deliv(deliv_cnt + 1, 50);
    req = '0; rd_ready = '0;
    step(2);

    // bist_mode blocks new pops but not the one in flight
    bist_mode = 1'b1; push(8'h60); req = 2'b01; rd_ready = 2'b01;
    step(20);
    bist_mode = 1'b0;
    step(1);
    bist_mode = 1'b1;
    wait_deliv(deliv_cnt + 1, 50);
    bist_mode = 1'b0; req = '0; rd_ready = '0;
    step(2);

    // reset while settling drops the character
    do_reset();
    push(8'h70); req = 2'b01; rd_ready = 2'b00;
    wait_pop(50);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0; req = '0;
    step(3);

    // sticky overflow, clear, and set-wins-over-clear
    fifo_overflow = 1'b1; step(1); fifo_overflow = 1'b0;
    step(5);
    clr_status = 1'b1; step(1); clr_status = 1'b0;
    step(2);
    fifo_overflow = 1'b1; clr_status = 1'b1; step(1);
    fifo_overflow = 1'b0; clr_status = 1'b0;
    step(2);
    clr_status = 1'b1; step(1); clr_status = 1'b0;
    step(2);

    // counter wrap from a preloaded 0xFFFF
    force dut.pop_cnt = 16'hFFFF;
    preload_seq++;
    #1;
    release dut.pop_cnt;
    step(1);
    push(8'h77); req = 2'b01; rd_ready = 2'b01;
    wait_deliv(deliv_cnt + 1, 50);
    req = '0; rd_ready = '0;
    step(2);

    // clear coincident with a delivery
    push(8'h78); req = 2'b01; rd_ready = 2'b00;
    wait_valid(50);
    clr_status = 1'b1; rd_ready = 2'b01;
    step(1);
    clr_status = 1'b0; rd_ready = '0; req = '0;
    step(3);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      req           = 2'($urandom_range(0, 3));
      rd_ready      = 2'($urandom_range(0, 3));
      bist_mode     = ($urandom_range(0, 9) == 0);
      fifo_overflow = ($urandom_range(0, 49) == 0);
      clr_status    = ($urandom_range(0, 39) == 0);
      if ((wr_ptr - rd_ptr) < 4 && $urandom_range(0, 2) == 0) push(8'($urandom_range(0, 255)));
      step(1);
    end

    // drain
    bist_mode = 1'b0; fifo_overflow = 1'b0; clr_status = 1'b0;
    req = 2'b11; rd_ready = 2'b11;
    step(80);
    req = '0; rd_ready = '0;
    step(3);
    tb_done = 1'b1;
    step(5);
  end

endmodule

// File: doc/rx_fifo_read_arb.md
RX_FIFO_READ_ARB -- requirements
Module: rx_fifo_read_arb

Interface
REQ-001 Parameter DATA_BITS, default 8, width of one received character.
REQ-002 Parameter POP_CYCLES, default 1, range 1..4, number of cycles pop_data is held high per pop.
REQ-003 Parameter SETTLE_CYCLES, default 1, range 1..4, number of cycles waited after pop_data falls before fifo_data is sampled.
REQ-004 Port: clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 Port: rst, input, 1, reset; synchronous, active-high.
REQ-006 Port: fifo_empty, input, 1, FIFO empty flag.
REQ-007 Port: fifo_overflow, input, 1, FIFO overflow flag.
REQ-008 Port: fifo_data, input, DATA_BITS, FIFO data output.
REQ-009 Port: bist_mode, input, 1, high blocks the start of new pops.
REQ-010 Port: pop_data, output, 1, registered pop strobe to the FIFO.
REQ-011 Port: req, input, 2, per-requester read request.
REQ-012 Port: rd_ready, input, 2, per-requester acceptance of rd_data.
REQ-013 Port: rd_valid, output, 2, per-requester valid; at most one bit is high.
REQ-014 Port: rd_data, output, DATA_BITS, registered character, shared by both requesters.
REQ-015 Port: busy, output, 1, high in every state except IDLE.
REQ-016 Port: ovf_sticky, output, 1, latched fifo_overflow.
REQ-017 Port: clr_status, input, 1, clears ovf_sticky and pop_cnt.
REQ-018 Port: pop_cnt, output, 16, count of completed deliveries; wraps modulo 2^16.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, POP, SETTLE, DELIVER.
REQ-020 IDLE SHALL go to POP when bist_mode=0, fifo_empty=0 and |req=1; it SHALL register the grant index on that same edge.
REQ-021 Arbitration SHALL be round-robin: a sole requester wins, and on a tie the requester not granted last wins.
REQ-022 The last-grant pointer SHALL update only on delivery completion; its reset value is 1, so requester 0 wins the first tie.
REQ-023 In POP, pop_data=1 for exactly POP_CYCLES cycles, then the FSM goes to SETTLE with pop_data=0.
REQ-024 SETTLE SHALL last SETTLE_CYCLES cycles; on exit, rd_data<=fifo_data, and the FSM enters DELIVER.
REQ-025 With default parameters: request sampled in IDLE at edge k -> pop_data high in cycle k+1 -> rd_valid[grant] high from cycle k+3.
REQ-026 In DELIVER, rd_valid[grant]=1 and rd_data SHALL be held stable until rd_ready[grant]=1.
REQ-027 In the cycle where rd_ready[grant]=1 is sampled: rd_valid clears next edge, pop_cnt increments, the last-grant pointer updates, and the FSM returns to IDLE.
REQ-028 After a grant, deassertion of req SHALL be ignored; the popped character is never discarded.
REQ-029 rd_ready of the non-granted requester SHALL be ignored.
REQ-030 bist_mode asserted after IDLE SHALL NOT abort the transaction in flight; it only blocks the next IDLE->POP transition.
REQ-031 fifo_empty SHALL be evaluated only in IDLE; consecutive pops are separated by at least one IDLE cycle.
REQ-032 ovf_sticky SHALL set on any cycle with fifo_overflow=1 and clear on clr_status=1; if both occur in the same cycle, set wins.
REQ-033 clr_status SHALL zero pop_cnt; clr_status coincident with a delivery SHALL yield pop_cnt=0.
REQ-034 The 16-bit pop_cnt SHALL wrap 0xFFFF->0x0000 without a flag.

Reset
REQ-035 On rst=1 at a clock edge: state=IDLE, pop_data=0, rd_valid=00, rd_data=0, busy=0, ovf_sticky=0, pop_cnt=0, last-grant=1, and internal counters=0.
REQ-036 Reset mid-transaction SHALL drop pop_data and rd_valid on that edge; the character is lost and no count is recorded.
REQ-037 rst SHALL have priority over every other input.

Structure
REQ-038 Package uart_pkg SHALL hold the DATA_BITS default, the state enum typedef (IDLE/POP/SETTLE/DELIVER), NUM_REQ=2, and the pop_cnt width constant 16.
REQ-039 The round-robin selection SHALL be a sub-module rr_arb2 (req[1:0], last_grant -> grant index, grant_valid), purely combinational.
REQ-040 All outputs SHALL be registered.

Verification
REQ-041 Test: FIFO holding 0x41, req=01, rd_ready=01 -> one pop_data pulse, rd_valid=01 at k+3, rd_data=0x41, pop_cnt=1.
REQ-042 Test: req=11 held, FIFO 0x10,0x11,0x12 -> grants 0,1,0; rd_data 0x10,0x11,0x12 in order; three pops.
REQ-043 Test: rd_ready low for 10 cycles in DELIVER -> rd_valid and rd_data stable, no second pop; req dropped meanwhile -> still delivered.
REQ-044 Test: bist_mode=1 with FIFO non-empty and req=01 -> no pop for 20 cycles; bist_mode raised during POP -> transaction completes.
REQ-045 Test: rst in SETTLE -> next cycle pop_data=0, rd_valid=00, busy=0, pop_cnt unchanged at 0.
REQ-046 Test: fifo_overflow pulse -> ovf_sticky=1 until clr_status; pop_cnt preloaded to 0xFFFF plus one delivery -> 0x0000.
